// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: ball FSM states, direction encoding and the
// default playfield/paddle geometry used by the renderer, paddle and ball logic.
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_MOVING = 2'd1,
    ST_LOST   = 2'd2
  } ball_state_e;

  // Direction bit: POS moves toward larger coordinates (right / down).
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_PADDLE_W  = 64;
  localparam int DEF_PADDLE_Y  = 440;
  localparam int DEF_STEP      = 2;

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: advance by step in the current direction and
// reflect off the low wall (0) or the high wall (limit), clamping to the wall.
module ball_axis
  import breakout_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] pos_i,
  input  logic         dir_i,
  input  logic [W-1:0] step_i,
  input  logic [W:0]   limit_i,
  output logic [W-1:0] next_pos_o,
  output logic         next_dir_o,
  output logic         saturated_o
);

  // One extra bit of headroom so the sum can never wrap.
  logic [W:0] pos_e, step_e, sum_e;

  assign pos_e  = {1'b0, pos_i};
  assign step_e = {1'b0, step_i};
  assign sum_e  = pos_e + step_e;

  // Step or clamp-and-reflect against whichever wall we are heading toward.
  always_comb begin
    next_pos_o  = pos_i;
    next_dir_o  = dir_i;
    saturated_o = 1'b0;
    if (dir_i == DIR_NEG) begin
      if (pos_e < step_e) begin
        next_pos_o  = '0;
        next_dir_o  = DIR_POS;
        saturated_o = 1'b1;
      end else begin
        next_pos_o  = W'(pos_e - step_e);
      end
    end else begin
      if (sum_e > limit_i) begin
        next_pos_o  = limit_i[W-1:0];
        next_dir_o  = DIR_NEG;
        saturated_o = 1'b1;
      end else begin
        next_pos_o  = sum_e[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Breakout ball controller: serve on the paddle, move one step per game tick,
// reflect off side/top walls and the paddle, report a lost ball.
// Optional BALL_SPEEDUP_EN: every 4th paddle hit raises the step by one,
// capped at STEP+2, restored when the ball returns to the paddle.
module ball_controller
  import breakout_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int PADDLE_W  = DEF_PADDLE_W,
  parameter int PADDLE_Y  = DEF_PADDLE_Y,
  parameter int STEP      = DEF_STEP
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       hit_paddle,
  output logic       life_lost
);

  localparam logic [10:0] X_LIM     = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_FLOOR   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] BS11      = 11'(BALL_SIZE);
  localparam logic [10:0] PY11      = 11'(PADDLE_Y);
  localparam logic [10:0] PW11      = 11'(PADDLE_W);
  localparam logic [10:0] SERVE_OFF = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  SERVE_Y   = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0]  RST_X     = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  STEP0     = 10'(STEP);

  ball_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        hit_q, hit_d;
  logic [9:0]  step;

  logic [9:0]  nx, ny, serve_x;
  logic        ndx, ndy, sx, sy, paddle_hit;
  logic [10:0] x11, y11, px11, s11;

  assign x11     = {1'b0, x_q};
  assign y11     = {1'b0, y_q};
  assign px11    = {1'b0, paddle_x};
  assign s11     = {1'b0, step};
  assign serve_x = 10'(px11 + SERVE_OFF);

  ball_axis #(.W(10)) u_axis_x (
    .pos_i(x_q), .dir_i(dx_q), .step_i(step), .limit_i(X_LIM),
    .next_pos_o(nx), .next_dir_o(ndx), .saturated_o(sx)
  );

  // Y only reflects off the top wall here; the downward limit is out of reach
  // because the paddle and floor checks below take over before it matters.
  ball_axis #(.W(10)) u_axis_y (
    .pos_i(y_q), .dir_i(dy_q), .step_i(step), .limit_i(11'h7FF),
    .next_pos_o(ny), .next_dir_o(ndy), .saturated_o(sy)
  );

  // Paddle contact uses the pre-move x and a y window that the coming step crosses.
  assign paddle_hit = (y11 + BS11 <= PY11) && (y11 + s11 + BS11 >= PY11) &&
                      (x11 + BS11 > px11) && (x11 < px11 + PW11);

  // Next-state for the FSM, position and direction.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hit_d   = 1'b0;
    case (state_q)
      ST_SERVE: begin
        x_d = serve_x;
        y_d = SERVE_Y;
        if (launch) begin
          state_d = ST_MOVING;
          dx_d    = DIR_POS;
          dy_d    = DIR_NEG;
        end
      end
      ST_MOVING: begin
        if (tick) begin
          x_d = nx;
          if (sx) dx_d = ndx;
          if (dy_q == DIR_NEG) begin
            y_d = ny;
            if (sy) dy_d = ndy;
          end else if (paddle_hit) begin
            y_d   = SERVE_Y;
            dy_d  = DIR_NEG;
            hit_d = 1'b1;
          end else if (y11 + s11 >= Y_FLOOR) begin
            // Ball is lost: freeze where it is for the one LOST clock.
            state_d = ST_LOST;
            x_d     = x_q;
          end else begin
            y_d = ny;
          end
        end
      end
      ST_LOST: begin
        state_d = ST_SERVE;
        x_d     = serve_x;
        y_d     = SERVE_Y;
        dx_d    = DIR_POS;
        dy_d    = DIR_NEG;
      end
      default: state_d = ST_SERVE;
    endcase
  end

  // Ball state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SERVE;
      x_q     <= RST_X;
      y_q     <= SERVE_Y;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_NEG;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hit_q   <= hit_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  localparam logic [9:0] STEP_MAX = 10'(STEP + 2);
  logic [1:0] cnt_q, cnt_d;
  logic [9:0] step_q, step_d;

  // Count paddle hits; each counter wrap bumps the step until the cap.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = step_q;
    if (state_q != ST_MOVING) begin
      cnt_d  = 2'd0;
      step_d = STEP0;
    end else if (hit_d) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3 && step_q < STEP_MAX) step_d = step_q + 10'd1;
    end
  end

  // Speed-up registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      step_q <= STEP0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = STEP0;
`endif

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign ball_active = (state_q == ST_MOVING);
  assign hit_paddle  = hit_q;
  assign life_lost   = (state_q == ST_LOST);

endmodule

// File: doc/ball_controller.md
# ball_controller

Moves the Breakout ball one step per game tick and bounces it off the side walls, the top wall and the paddle. Detects a lost ball. Consumes the single-cycle `tick` pulse from the game-tick timer and the paddle position from the paddle logic. Drives the registered ball coordinates read by the video renderer.

## Interface
- `SCREEN_W`, 640: playfield width in pixels
- `SCREEN_H`, 480: playfield height in pixels
- `BALL_SIZE`, 8: ball side length in pixels (square)
- `PADDLE_W`, 64: paddle width in pixels
- `PADDLE_Y`, 440: y of the paddle's top edge
- `STEP`, 2: pixels moved per tick on each axis
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `tick`  in  1  one-cycle game-tick pulse
- `launch`  in  1  serve request, level, sampled every clock
- `paddle_x`  in  10  paddle left edge
- `ball_x`  out  10  ball left edge, registered
- `ball_y`  out  10  ball top edge, registered
- `ball_active`  out  1  high while in MOVING
- `hit_paddle`  out  1  one-cycle pulse on a paddle bounce
- `life_lost`  out  1  one-cycle pulse on entering LOST

## Operation
- States:
  - SERVE: ball rides the paddle. Every clock: `ball_x = paddle_x + PADDLE_W/2 - BALL_SIZE/2`, `ball_y = PADDLE_Y - BALL_SIZE`.
  - SERVE → MOVING: on `launch=1`. Direction is set to dx=+1 (right), dy=-1 (up).
  - MOVING: on each `tick`, both axes update independently in the same cycle. `launch` is ignored.
  - LOST: lasts one clock, with `life_lost=1`. Always returns to SERVE.
- All coordinate math is unsigned 11-bit internally, so there is no underflow or overflow. Results are truncated to 10 bits.
- X axis:
  - Moving left with `ball_x < step`: `ball_x=0`, dx becomes +1.
  - Moving right with `ball_x + step > SCREEN_W - BALL_SIZE`: `ball_x = SCREEN_W - BALL_SIZE`, dx becomes -1.
  - Otherwise: `ball_x ± step`.
- Y axis:
  - Moving up with `ball_y < step`: `ball_y=0`, dy becomes +1.
  - Paddle bounce, when all of these hold:
    - moving down;
    - `ball_y + BALL_SIZE <= PADDLE_Y`;
    - `ball_y + step + BALL_SIZE >= PADDLE_Y`;
    - `ball_x + BALL_SIZE > paddle_x`;
    - `ball_x < paddle_x + PADDLE_W`.
  - On a paddle bounce: `ball_y = PADDLE_Y - BALL_SIZE`, dy becomes -1, `hit_paddle=1`.
  - Otherwise, moving down with `ball_y + step >= SCREEN_H - BALL_SIZE`: go to LOST. Position holds.
  - Otherwise: `ball_y ± step`.
- Paddle overlap uses the pre-update `ball_x`.
- A corner hit (both axes saturating on one tick) reflects both directions in that tick.

## Timing
- Reset values:
  - state SERVE
  - `ball_x = SCREEN_W/2 - BALL_SIZE/2` (316)
  - `ball_y = PADDLE_Y - BALL_SIZE` (432)
  - dx=+1, dy=-1, step=STEP
  - `ball_active=0`, `hit_paddle=0`, `life_lost=0`
- Reset is asynchronous and may assert mid-flight. All state returns to the reset values immediately.
- A position update is visible on outputs the clock after the `tick`-high cycle.
- `ball_active` rises the clock after `launch` is sampled. It falls in the same clock that `life_lost` rises.
- `tick` and `launch` high in the same SERVE cycle: launch wins. No motion occurs in that cycle; motion starts on the next tick.
- `tick` during LOST is dropped.
- `hit_paddle` and `life_lost` are never high together.
- In SERVE, the ball tracks `paddle_x` with one clock latency.

## Configuration
- `BALL_SPEEDUP_EN`:
  - Defined: a 2-bit paddle-hit counter increments on each `hit_paddle`. When it wraps (every 4 hits), step increments by 1, saturating at `STEP+2`. Step and counter reset to `STEP`/0 on entering SERVE.
  - Undefined: step is constant `STEP`, and no counter is built.

## Structure
- Shared package `breakout_pkg` holds:
  - state enum (SERVE, MOVING, LOST)
  - direction constants (DIR_POS, DIR_NEG)
  - default screen and paddle constants, shared with the renderer and paddle logic
- Sub-module `ball_axis`: one axis of step-and-wall-reflect.
  - Inputs: pos, dir, step, limit.
  - Outputs: next_pos, next_dir, saturated.
  - Instantiated for X. Y reuses it for the top wall; the paddle and bottom checks live in `ball_controller`.

## Test plan
- Release reset with `paddle_x=100`, `launch=0` → `ball_x=128`, `ball_y=432`, `ball_active=0` after one clock.
- Launch, then 1 tick with STEP=2 → `ball_x=130`, `ball_y=430`, `ball_active=1`.
- Force the ball to `x=1` moving left, apply a tick → `ball_x=0`, the next tick gives `ball_x=2`. Corner at `x=631`, `y=1` → `ball_x=632`, `ball_y=0`, both directions flip.
- Ball moving down at `y=431` with paddle under it, apply a tick → `ball_y=432`, `hit_paddle` pulses 1 clock, dy=up. The same case with the paddle moved away → no hit.
- Ball reaches `y>=470` → `life_lost` 1-clock pulse, back to SERVE. Next clock the ball is on the paddle. `tick`+`launch` together in SERVE → no motion that cycle.
- With `BALL_SPEEDUP_EN`: 4 paddle hits → step becomes 3, 8 hits → 4, 12 hits → still 4. Assert `reset` mid-flight → outputs equal the reset values asynchronously.
